data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target side of the CPU's load/store interface.
- Accepts one doubleword (64-bit) read or write request at a time over a valid/ready handshake, waits a programmable latency, performs the access, and returns a held response with data and error status.
- Replaces the zero-latency RAM model so the datapath can be exercised against a stalling memory.

---
 rtl/data_mem_responder.sv | 109 ++++++++++
 tb/tb_data_mem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle doubleword data-memory responder with a programmable access latency.
// One request in flight; the access is performed on the edge that enters RESP.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [63:0] LIMIT    = 64'(DEPTH) << 3;
  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]  LAT_LOAD = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          cap_write;
  logic [63:0]   cap_addr;
  logic [63:0]   cap_wdata;
  logic [63:0]   mem [DEPTH];

  logic          commit;
  logic          c_write;
  logic [63:0]   c_addr;
  logic [63:0]   c_wdata;
  logic          c_err;
  logic [AW-1:0] c_idx;

  // With zero latency the commit edge is the accept edge, so the access
  // operands come straight from the request port instead of the capture regs.
  always_comb begin
    commit  = ((state == S_IDLE) && req_valid && ZERO_LAT) ||
              ((state == S_WAIT) && (cnt == '0));
    c_write = (state == S_IDLE) ? req_write : cap_write;
    c_addr  = (state == S_IDLE) ? req_addr  : cap_addr;
    c_wdata = (state == S_IDLE) ? req_wdata : cap_wdata;
    c_err   = (c_addr[2:0] != 3'b000) || (c_addr >= LIMIT);
    c_idx   = c_addr[AW+2:3];
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            if (ZERO_LAT) begin
              state <= S_RESP;
            end else begin
              cnt   <= LAT_LOAD;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        resp_err   <= c_err;
        resp_rdata <= (!c_write && !c_err) ? mem[c_idx] : '0;
      end else if ((state == S_RESP) && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Array is deliberately not reset; a store caught by reset never commits.
  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err && !rst) mem[c_idx] <= c_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 0, 3) against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_data_mem_responder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 0;
  logic        req_valid  = 1'b0;
  logic        req_write  = 1'b0;
  logic        resp_ready = 1'b1;
  logic [63:0] req_addr   = '0;
  logic [63:0] req_wdata  = '0;

  logic        rv [NI];
  logic        rr [NI];
  logic        vv [NI];
  logic        er [NI];
  logic        bz [NI];
  logic [63:0] rd [NI];

  int errors = 0;
  int checks = 0;

  assign rv[0] = req_valid && (sel == 0);
  assign rv[1] = req_valid && (sel == 1);
  assign rv[2] = req_valid && (sel == 2);

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(64), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vv[0]), .resp_ready(resp_ready),
    .resp_rdata(rd[0]), .resp_err(er[0]), .busy(bz[0]));

  data_mem_responder #(.DEPTH(64), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vv[1]), .resp_ready(resp_ready),
    .resp_rdata(rd[1]), .resp_err(er[1]), .busy(bz[1]));

  data_mem_responder #(.DEPTH(64), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rr[2]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vv[2]), .resp_ready(resp_ready),
    .resp_rdata(rd[2]), .resp_err(er[2]), .busy(bz[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [inst %0d]: got %h, expected %h", nm, inst, act, exp);
    end
  endtask

  // Transaction model: a request is pending from accept until the response
  // is consumed; its result is fixed at accept edge + LATENCY.
  int          cyc = 0;
  bit          m_busy     [NI];
  bit          m_valid    [NI];
  bit          m_write    [NI];
  bit          m_err      [NI];
  bit          m_known_rd [NI];
  logic [63:0] m_addr     [NI];
  logic [63:0] m_wdata    [NI];
  logic [63:0] m_rdata    [NI];
  int          m_resp_at  [NI];
  logic [63:0] m_mem      [NI][64];
  bit          m_known    [NI][64];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        m_busy[i] = 0; m_valid[i] = 0; m_err[i] = 0;
        m_rdata[i] = '0; m_known_rd[i] = 1;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (m_valid[i]) begin
          if (resp_ready) begin
            m_valid[i] = 0; m_busy[i] = 0; m_err[i] = 0;
            m_rdata[i] = '0; m_known_rd[i] = 1;
          end
        end else if (!m_busy[i] && rv[i]) begin
          m_busy[i]    = 1;
          m_write[i]   = req_write;
          m_addr[i]    = req_addr;
          m_wdata[i]   = req_wdata;
          m_resp_at[i] = cyc + lat_of(i);
        end
        if (m_busy[i] && !m_valid[i] && cyc == m_resp_at[i]) begin
          int idx;
          m_err[i]      = (m_addr[i] % 8 != 0) || (m_addr[i] >= 64 * 8);
          m_valid[i]    = 1;
          m_rdata[i]    = '0;
          m_known_rd[i] = 1;
          if (!m_err[i]) begin
            idx = int'(m_addr[i] / 8);
            if (m_write[i]) begin
              m_mem[i][idx]   = m_wdata[i];
              m_known[i][idx] = 1;
            end else begin
              m_rdata[i]    = m_mem[i][idx];
              m_known_rd[i] = m_known[i][idx];
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("req_ready", i, rr[i], !m_busy[i]);
      chk("busy", i, bz[i], m_busy[i]);
      chk("resp_valid", i, vv[i], m_valid[i]);
      chk("resp_err", i, er[i], m_err[i]);
      if (m_known_rd[i]) chk("resp_rdata", i, rd[i], m_rdata[i]);
    end
  end

  task automatic txn(input int inst, input logic wr, input logic [63:0] a, input logic [63:0] d,
                     output logic [63:0] rdata, output logic err, output int lat, output int acc);
    int k = 0;
    @(negedge clk);
    sel = inst; req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = a ^ 64'h8; req_wdata = ~d;
    while (!vv[inst] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("resp_seen", inst, vv[inst], 1'b1);
    lat   = cyc + 1 - acc;
    rdata = rd[inst];
    err   = er[inst];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rdat;
    logic        err;
    int          lat, acc, prev_acc, k;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 0, rr[0], 1'b1);
    chk("rst_resp_valid", 0, vv[0], 1'b0);
    chk("rst_rdata", 0, rd[0], 64'h0);
    chk("rst_err", 0, er[0], 1'b0);
    chk("rst_busy", 0, bz[0], 1'b0);
    rst = 1'b0;

    // Pre-seed locations used later.
    txn(0, 1'b1, 64'h10, 64'h5, rdat, err, lat, acc);
    txn(0, 1'b1, 64'h1F8, 64'hAA, rdat, err, lat, acc);

    // Reset during WAIT of a store: the store must never commit.
    @(negedge clk);
    sel = 0; req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #2 chk("rstw_busy", 0, bz[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("rstw_no_resp", 0, vv[0], 1'b0);
    end
    txn(0, 1'b0, 64'h10, 64'h0, rdat, err, lat, acc);
    chk("rstw_load", 0, rdat, 64'h5);

    // Basic store/load with LATENCY=2.
    txn(0, 1'b1, 64'h18, 64'h0123_4567_89AB_CDEF, rdat, err, lat, acc);
    chk("st_lat", 0, 64'(lat), 64'd3);
    chk("st_err", 0, err, 1'b0);
    chk("st_rdata", 0, rdat, 64'h0);
    txn(0, 1'b0, 64'h18, 64'h0, rdat, err, lat, acc);
    chk("ld_lat", 0, 64'(lat), 64'd3);
    chk("ld_rdata", 0, rdat, 64'h0123_4567_89AB_CDEF);

    // Misaligned and out-of-range.
    txn(0, 1'b0, 64'h1C, 64'h0, rdat, err, lat, acc);
    chk("mis_err", 0, err, 1'b1);
    chk("mis_rdata", 0, rdat, 64'h0);
    txn(0, 1'b1, 64'h200, 64'h7, rdat, err, lat, acc);
    chk("oor_err", 0, err, 1'b1);
    chk("oor_rdata", 0, rdat, 64'h0);
    txn(0, 1'b0, 64'h1F8, 64'h0, rdat, err, lat, acc);
    chk("oor_untouched", 0, rdat, 64'hAA);
    chk("oor_untouched_err", 0, err, 1'b0);

    // Response backpressure with req_valid held high.
    @(negedge clk);
    resp_ready = 1'b0; sel = 0; req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h18;
    @(posedge clk);
    #1 acc = cyc;
    k = 0;
    @(negedge clk);
    while (!vv[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_seen", 0, vv[0], 1'b1);
    chk("bp_lat", 0, 64'(cyc + 1 - acc), 64'd3);
    for (int j = 0; j < 5; j++) begin
      chk("bp_valid", 0, vv[0], 1'b1);
      chk("bp_rdata", 0, rd[0], 64'h0123_4567_89AB_CDEF);
      chk("bp_req_ready", 0, rr[0], 1'b0);
      if (j < 4) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", 0, vv[0], 1'b0);
    chk("bp_hs_ready", 0, rr[0], 1'b1);
    @(posedge clk);
    #1 chk("bp_reaccept", 0, bz[0], 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!vv[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_second_rdata", 0, rd[0], 64'h0123_4567_89AB_CDEF);

    // LATENCY=0.
    txn(1, 1'b1, 64'h0, 64'h42, rdat, err, lat, acc);
    chk("l0_st_lat", 1, 64'(lat), 64'd1);
    prev_acc = acc;
    txn(1, 1'b0, 64'h0, 64'h0, rdat, err, lat, acc);
    chk("l0_ld_lat", 1, 64'(lat), 64'd1);
    chk("l0_ld_rdata", 1, rdat, 64'h42);
    chk("l0_spacing", 1, 64'(acc - prev_acc), 64'd2);

    // Back-to-back alternating store/load with LATENCY=3.
    prev_acc = 0;
    for (int n = 0; n < 8; n++) begin
      txn(2, 1'b1, 64'(n * 8), 64'(n), rdat, err, lat, acc);
      chk("b2b_st_lat", 2, 64'(lat), 64'd4);
      if (n > 0) chk("b2b_spacing", 2, 64'(acc - prev_acc), 64'd5);
      prev_acc = acc;
      txn(2, 1'b0, 64'(n * 8), 64'h0, rdat, err, lat, acc);
      chk("b2b_ld_rdata", 2, rdat, 64'(n));
      chk("b2b_spacing", 2, 64'(acc - prev_acc), 64'd5);
      prev_acc = acc;
    end

    repeat (3) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
